// File: rtl/seq_mult_32bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_32bit
// Function : Sequential unsigned shift-and-add multiplier. Drives an external
//            combinational WIDTH-bit adder and folds its Sum/Cout back into a
//            {acc,q} shift register, one multiplier bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   Add_A,
  output logic [WIDTH-1:0]   Add_B,
  output logic               Add_Cin,
  input  logic [WIDTH-1:0]   Add_Sum,
  input  logic               Add_Cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value at which the final shift happens.
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Adder operands: only meaningful while iterating, forced to zero otherwise.
  always_comb begin
    Add_A   = '0;
    Add_B   = '0;
    Add_Cin = 1'b0;
    if (state_q == S_CALC) begin
      Add_A = acc_q;
      Add_B = q_q[0] ? mcand_q : '0;
    end
  end

  // Next-state logic; busy/done are computed from the upcoming state so the
  // registered copies line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = Multiplicand;
          q_d     = Multiplier;
          acc_d   = '0;
          count_d = '0;
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        // Carry-out becomes the new accumulator MSB, so nothing is lost.
        acc_d   = {Add_Cout, Add_Sum[WIDTH-1:1]};
        q_d     = {Add_Sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == c_last_iter) begin
          product_d = {Add_Cout, Add_Sum, q_q[WIDTH-1:1]};
          state_d   = S_DONE;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        // start is deliberately ignored here; it must be reasserted in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_32bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_32bit
// Function : Directed self-checking bench for seq_mult_32bit with a behavioural
//            combinational adder closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_32bit;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              busy;
  logic              done;
  logic [63:0]       product;
  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic              add_cin;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;

  int          total = 0;
  int          passed = 0;
  logic [63:0] last_prod;

  seq_mult_32bit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Multiplicand (multiplicand),
    .Multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .Product      (product),
    .Add_A        (add_a),
    .Add_B        (add_b),
    .Add_Cin      (add_cin),
    .Add_Sum      (add_sum),
    .Add_Cout     (add_cout)
  );

  // External combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One multiply; optional stray start pulse at CALC cycle inj (-1 = none).
  // Returns at the negedge of the DONE cycle (or after the cycle bound).
  task automatic run_mult(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input int inj);
    logic [63:0] exp;
    int busy_cnt, done_cnt, done_at, cin_bad, busy_at_done;
    exp = {32'b0, m} * {32'b0, q};
    @(negedge clk);
    check({tag, "/idle_done"}, {63'b0, done}, 64'd0);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(posedge clk);
    busy_cnt = 0; done_cnt = 0; done_at = -1; cin_bad = 0; busy_at_done = -1;
    for (int i = 0; i < 64 && done_cnt == 0; i++) begin
      @(negedge clk);
      start        = (i == inj);
      multiplicand = (i == inj) ? 32'd2 : $urandom;
      multiplier   = (i == inj) ? 32'd2 : $urandom;
      if (busy) busy_cnt++;
      if (add_cin !== 1'b0) cin_bad++;
      if (i == 0) begin
        check({tag, "/add_a0"}, {32'b0, add_a}, 64'd0);
        check({tag, "/add_b0"}, {32'b0, add_b}, q[0] ? {32'b0, m} : 64'd0);
      end
      if (i == 5) check({tag, "/hold"}, product, last_prod);
      if (done) begin
        done_cnt++;
        done_at = i;
        busy_at_done = int'(busy);
      end
    end
    start = 1'b0;
    check({tag, "/done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "/done_edges"}, 64'(done_at + 1), 64'd33);
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "/busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "/cin"}, 64'(cin_bad), 64'd0);
    check({tag, "/product"}, product, exp);
    last_prod = exp;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    logic [31:0] rm, rq;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", {63'b0, busy}, 64'd0);
    check("rst/done", {63'b0, done}, 64'd0);
    check("rst/product", product, 64'd0);
    check("rst/add_a", {32'b0, add_a}, 64'd0);
    check("rst/add_b", {32'b0, add_b}, 64'd0);
    rst = 1'b0;
    last_prod = 64'd0;

    run_mult("m3q5", 32'd3, 32'd5, -1);
    run_mult("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("ones/literal", product, 64'hFFFF_FFFE_0000_0001);
    run_mult("zero", 32'd0, 32'h1234_5678, -1);
    run_mult("overlap", 32'd7, 32'd9, 10);
    check("overlap/literal", product, 64'd63);
    run_mult("b2b", 32'd2, 32'd2, -1);
    check("b2b/literal", product, 64'd4);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 32'd100;
    multiplier = 32'd50;
    @(posedge clk);
    for (int i = 0; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort/busy_pre", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort/busy", {63'b0, busy}, 64'd0);
    check("abort/done", {63'b0, done}, 64'd0);
    check("abort/product", product, 64'd0);
    check("abort/add_a", {32'b0, add_a}, 64'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort/no_activity", 64'(dcnt), 64'd0);
    last_prod = 64'd0;
    run_mult("m100q50", 32'd100, 32'd50, -1);
    check("m100q50/literal", product, 64'd5000);

    // Random operand pairs against the golden product.
    for (int k = 0; k < 10; k++) begin
      rm = $urandom;
      rq = $urandom;
      run_mult($sformatf("rand%0d", k), rm, rq, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
